// File: rtl/axi_burst_master.sv
// AXI-style burst master: independent read and write engines turning one-cycle
// user requests into full VALID/READY handshake sequences with beat counting.
//
// state  | meaning
// R_IDLE | read engine waiting for rd_req
// R_ADDR | ARVALID up, holding AR fields until ARREADY
// R_DATA | RREADY up, accepting beats until RLAST
// W_IDLE | write engine waiting for wr_req
// W_ADDR | AWVALID up, holding AW fields until AWREADY
// W_DATA | WVALID up, streaming wr_data until the len-th beat
// W_RESP | BREADY up, waiting for BVALID
module axi_burst_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int RESP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic [ID_W-1:0]   rd_id,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_done,
  output logic [RESP_W-1:0] rd_resp,
  output logic              rd_len_err,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [ID_W-1:0]   wr_id,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic              wr_busy,
  output logic              wr_done,
  output logic [RESP_W-1:0] wr_resp,
  output logic              ARVALID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [LEN_W-1:0]  ARLEN,
  output logic [ID_W-1:0]   ARID,
  input  logic              ARREADY,
  input  logic              RVALID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [RESP_W-1:0] RRESP,
  input  logic              RLAST,
  output logic              RREADY,
  output logic              AWVALID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [LEN_W-1:0]  AWLEN,
  output logic [ID_W-1:0]   AWID,
  input  logic              AWREADY,
  output logic              WVALID,
  output logic [DATA_W-1:0] WDATA,
  output logic              WLAST,
  input  logic              WREADY,
  input  logic              BVALID,
  input  logic [RESP_W-1:0] BRESP,
  output logic              BREADY
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  localparam logic [LEN_W:0] R_CNT_MAX = {1'b1, {LEN_W{1'b0}}};

  r_state_t          r_state_q, r_state_d;
  w_state_t          w_state_q, w_state_d;
  logic [LEN_W:0]    r_cnt_q, r_cnt_inc, r_exp_beats;
  logic [RESP_W-1:0] r_acc_q, r_acc_next;
  logic [LEN_W-1:0]  w_cnt_q;
  logic              r_beat, w_beat, w_last_beat;

  assign r_beat      = RVALID && RREADY;
  assign w_beat      = WVALID && WREADY;
  assign w_last_beat = w_beat && (w_cnt_q == AWLEN);

  // Write data path is combinational so the user can stream a FIFO head directly.
  assign WDATA  = WVALID ? wr_data : '0;
  assign WLAST  = WVALID && (w_cnt_q == AWLEN);
  assign wr_pop = w_beat;

  always_comb begin
    r_cnt_inc   = (r_cnt_q == R_CNT_MAX) ? r_cnt_q : r_cnt_q + 1'b1;
    r_acc_next  = (RRESP > r_acc_q) ? RRESP : r_acc_q;
    r_exp_beats = {1'b0, ARLEN} + {{LEN_W{1'b0}}, 1'b1};
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (rd_req) r_state_d = R_ADDR;
      R_ADDR:  if (ARREADY) r_state_d = R_DATA;
      R_DATA:  if (r_beat && RLAST) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (wr_req) w_state_d = W_ADDR;
      W_ADDR:  if (AWREADY) w_state_d = W_DATA;
      W_DATA:  if (w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (BVALID) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q  <= R_IDLE;
      ARVALID    <= 1'b0;
      ARADDR     <= '0;
      ARLEN      <= '0;
      ARID       <= '0;
      RREADY     <= 1'b0;
      rd_busy    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      rd_done    <= 1'b0;
      rd_resp    <= '0;
      rd_len_err <= 1'b0;
      r_cnt_q    <= '0;
      r_acc_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      ARVALID   <= (r_state_d == R_ADDR);
      RREADY    <= (r_state_d == R_DATA);
      rd_busy   <= (r_state_d != R_IDLE);
      rd_valid  <= r_beat;
      rd_last   <= r_beat && RLAST;
      rd_done   <= r_beat && RLAST;
      if (r_state_q == R_IDLE && rd_req) begin
        ARADDR  <= rd_addr;
        ARLEN   <= rd_len;
        ARID    <= rd_id;
        r_cnt_q <= '0;
        r_acc_q <= '0;
      end
      if (r_beat) begin
        rd_data <= RDATA;
        r_cnt_q <= r_cnt_inc;
        r_acc_q <= r_acc_next;
        if (RLAST) begin
          rd_resp    <= r_acc_next;
          rd_len_err <= (r_cnt_inc != r_exp_beats);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      AWVALID   <= 1'b0;
      AWADDR    <= '0;
      AWLEN     <= '0;
      AWID      <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      wr_busy   <= 1'b0;
      wr_done   <= 1'b0;
      wr_resp   <= '0;
      w_cnt_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      AWVALID   <= (w_state_d == W_ADDR);
      WVALID    <= (w_state_d == W_DATA);
      BREADY    <= (w_state_d == W_RESP);
      wr_busy   <= (w_state_d != W_IDLE);
      wr_done   <= (w_state_q == W_RESP) && BVALID;
      if (w_state_q == W_RESP && BVALID) wr_resp <= BRESP;
      if (w_state_q == W_IDLE && wr_req) begin
        AWADDR  <= wr_addr;
        AWLEN   <= wr_len;
        AWID    <= wr_id;
        w_cnt_q <= '0;
      end
      if (w_beat) w_cnt_q <= w_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: scripted slave tasks with
// scoreboard queues of expected read beats and write beats.
module tb_axi_burst_master;

  logic       clk, rst_n;
  logic       rd_req, rd_busy, rd_valid, rd_last, rd_done, rd_len_err;
  logic [7:0] rd_addr, rd_data;
  logic [3:0] rd_len, rd_id;
  logic [1:0] rd_resp;
  logic       wr_req, wr_pop, wr_busy, wr_done;
  logic [7:0] wr_addr, wr_data;
  logic [3:0] wr_len, wr_id;
  logic [1:0] wr_resp;
  logic       ARVALID, ARREADY, RVALID, RLAST, RREADY;
  logic [7:0] ARADDR, RDATA;
  logic [3:0] ARLEN, ARID;
  logic [1:0] RRESP;
  logic       AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic [7:0] AWADDR, WDATA;
  logic [3:0] AWLEN, AWID;
  logic [1:0] BRESP;

  axi_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_id(rd_id),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .rd_done(rd_done), .rd_resp(rd_resp), .rd_len_err(rd_len_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_id(wr_id),
    .wr_data(wr_data), .wr_pop(wr_pop), .wr_busy(wr_busy), .wr_done(wr_done),
    .wr_resp(wr_resp),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RREADY(RREADY),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWID(AWID), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] rd_exp_q[$];
  logic [8:0] wr_exp_q[$];
  logic [7:0] rd_src_data[16];
  logic [1:0] rd_src_resp[16];
  logic [7:0] wr_src[17];
  logic       wr_pat[8];
  int         wr_npat;

  task automatic run_read(input logic [7:0] addr, input logic [3:0] len,
                          input logic [3:0] id, input int nb, input int ar_delay);
    logic [1:0] worst;
    logic [8:0] exp;
    logic       exp_err;
    worst = 2'd0;
    for (int i = 0; i < nb; i++) begin
      rd_exp_q.push_back({(i == nb - 1), rd_src_data[i]});
      if (rd_src_resp[i] > worst) worst = rd_src_resp[i];
    end
    exp_err = (nb != int'(len) + 1);
    rd_req = 1'b1; rd_addr = addr; rd_len = len; rd_id = id;
    @(posedge clk); #1;
    rd_req = 1'b0;
    checks++;
    if (ARVALID !== 1'b1 || ARADDR !== addr || ARLEN !== len || ARID !== id) begin
      errors++;
      $display("FAIL ar_issue got ARVALID=%0b ARADDR=%h ARLEN=%0d ARID=%0d need 1 %h %0d %0d",
               ARVALID, ARADDR, ARLEN, ARID, addr, len, id);
    end
    checks++;
    if (rd_busy !== 1'b1 || rd_done !== 1'b0) begin
      errors++;
      $display("FAIL rd_busy_start got busy=%0b done=%0b need 1 0", rd_busy, rd_done);
    end
    for (int d = 0; d < ar_delay; d++) begin
      @(posedge clk); #1;
      checks++;
      if (ARVALID !== 1'b1 || ARADDR !== addr || RREADY !== 1'b0) begin
        errors++;
        $display("FAIL ar_hold got ARVALID=%0b ARADDR=%h RREADY=%0b need 1 %h 0",
                 ARVALID, ARADDR, RREADY, addr);
      end
    end
    ARREADY = 1'b1;
    @(posedge clk); #1;
    ARREADY = 1'b0;
    checks++;
    if (ARVALID !== 1'b0 || RREADY !== 1'b1) begin
      errors++;
      $display("FAIL ar_done got ARVALID=%0b RREADY=%0b need 0 1", ARVALID, RREADY);
    end
    for (int i = 0; i < nb; i++) begin
      RVALID = 1'b1; RDATA = rd_src_data[i]; RRESP = rd_src_resp[i]; RLAST = (i == nb - 1);
      @(posedge clk); #1;
      checks++;
      if (rd_exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_beat_extra got data=%h with empty scoreboard", rd_data);
      end else begin
        exp = rd_exp_q.pop_front();
        if (rd_valid !== 1'b1 || {rd_last, rd_data} !== exp) begin
          errors++;
          $display("FAIL rd_beat got valid=%0b last=%0b data=%h need 1 %0b %h",
                   rd_valid, rd_last, rd_data, exp[8], exp[7:0]);
        end
      end
      if (i < nb - 1) begin
        checks++;
        if (rd_done !== 1'b0) begin
          errors++;
          $display("FAIL rd_done_early got %0b need 0", rd_done);
        end
      end
    end
    RVALID = 1'b0; RLAST = 1'b0;
    checks++;
    if (rd_done !== 1'b1 || rd_resp !== worst || rd_len_err !== exp_err ||
        RREADY !== 1'b0 || rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_done got done=%0b resp=%0d len_err=%0b RREADY=%0b busy=%0b need 1 %0d %0b 0 0",
               rd_done, rd_resp, rd_len_err, RREADY, rd_busy, worst, exp_err);
    end
    checks++;
    if (rd_exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_scoreboard got %0d leftover beats need 0", rd_exp_q.size());
    end
  endtask

  task automatic run_write(input logic [7:0] addr, input logic [3:0] len,
                           input logic [3:0] id, input logic [1:0] bresp, input int b_delay);
    int         pops, pop_cnt, c;
    logic       hs;
    logic [8:0] exp;
    for (int i = 0; i <= int'(len); i++) wr_exp_q.push_back({(i == int'(len)), wr_src[i]});
    wr_data = wr_src[0];
    wr_req = 1'b1; wr_addr = addr; wr_len = len; wr_id = id;
    @(posedge clk); #1;
    wr_req = 1'b0;
    checks++;
    if (AWVALID !== 1'b1 || AWADDR !== addr || AWLEN !== len || AWID !== id || wr_busy !== 1'b1) begin
      errors++;
      $display("FAIL aw_issue got AWVALID=%0b AWADDR=%h AWLEN=%0d AWID=%0d busy=%0b need 1 %h %0d %0d 1",
               AWVALID, AWADDR, AWLEN, AWID, wr_busy, addr, len, id);
    end
    AWREADY = 1'b1;
    @(posedge clk); #1;
    AWREADY = 1'b0;
    checks++;
    if (AWVALID !== 1'b0 || WVALID !== 1'b1 || BREADY !== 1'b0) begin
      errors++;
      $display("FAIL aw_done got AWVALID=%0b WVALID=%0b BREADY=%0b need 0 1 0", AWVALID, WVALID, BREADY);
    end
    pops = 0; pop_cnt = 0; c = 0;
    while (pops <= int'(len) && c < 40) begin
      WREADY = (c < wr_npat) ? wr_pat[c] : 1'b1;
      #1;
      hs = WREADY;
      checks++;
      if (wr_exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_beat_extra got WDATA=%h with empty scoreboard", WDATA);
      end else begin
        exp = wr_exp_q[0];
        if (WVALID !== 1'b1 || {WLAST, WDATA} !== exp || wr_pop !== hs) begin
          errors++;
          $display("FAIL wr_beat got WVALID=%0b WLAST=%0b WDATA=%h pop=%0b need 1 %0b %h %0b",
                   WVALID, WLAST, WDATA, wr_pop, exp[8], exp[7:0], hs);
        end
        if (hs) void'(wr_exp_q.pop_front());
      end
      if (wr_pop === 1'b1) pop_cnt++;
      @(posedge clk); #1;
      if (hs) begin
        pops++;
        wr_data = wr_src[pops];
      end
      c++;
    end
    WREADY = 1'b0;
    checks++;
    if (c >= 40 || pop_cnt != int'(len) + 1) begin
      errors++;
      $display("FAIL wr_pop_count got %0d pops in %0d cycles need %0d", pop_cnt, c, int'(len) + 1);
    end
    checks++;
    if (WVALID !== 1'b0 || WLAST !== 1'b0 || BREADY !== 1'b1) begin
      errors++;
      $display("FAIL w_to_resp got WVALID=%0b WLAST=%0b BREADY=%0b need 0 0 1", WVALID, WLAST, BREADY);
    end
    for (int d = 0; d < b_delay; d++) begin
      @(posedge clk); #1;
      checks++;
      if (BREADY !== 1'b1 || wr_done !== 1'b0) begin
        errors++;
        $display("FAIL b_wait got BREADY=%0b wr_done=%0b need 1 0", BREADY, wr_done);
      end
    end
    BVALID = 1'b1; BRESP = bresp;
    @(posedge clk); #1;
    BVALID = 1'b0; BRESP = 2'd0;
    checks++;
    if (wr_done !== 1'b1 || wr_resp !== bresp || BREADY !== 1'b0 || wr_busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_done got done=%0b resp=%0d BREADY=%0b busy=%0b need 1 %0d 0 0",
               wr_done, wr_resp, BREADY, wr_busy, bresp);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [119:0] outs;
    outs = {ARVALID, ARADDR, ARLEN, ARID, RREADY, AWVALID, AWADDR, AWLEN, AWID,
            WVALID, WDATA, WLAST, BREADY, rd_busy, rd_valid, rd_data, rd_last,
            rd_done, rd_resp, rd_len_err, wr_pop, wr_busy, wr_done, wr_resp};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL %s got outputs=%h need all zero", name, outs);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_data = 8'h5A; WREADY = 1'b1; RVALID = 1'b1; RLAST = 1'b1; BVALID = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    WREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; BVALID = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_read_basic();
    rd_src_data[0] = 8'h11; rd_src_data[1] = 8'h22; rd_src_data[2] = 8'h33; rd_src_data[3] = 8'h44;
    for (int i = 0; i < 4; i++) rd_src_resp[i] = 2'd0;
    run_read(8'h10, 4'd3, 4'd5, 4, 2);
  endtask

  task automatic test_read_resp_accum();
    rd_src_data[0] = 8'h55; rd_src_data[1] = 8'h66;
    rd_src_resp[0] = 2'd0; rd_src_resp[1] = 2'd2;
    run_read(8'h24, 4'd1, 4'd2, 2, 0);
  endtask

  task automatic test_read_short();
    rd_src_data[0] = 8'h77; rd_src_data[1] = 8'h88;
    rd_src_resp[0] = 2'd0; rd_src_resp[1] = 2'd0;
    run_read(8'h30, 4'd2, 4'd3, 2, 1);
  endtask

  task automatic test_read_long();
    rd_src_data[0] = 8'h91; rd_src_data[1] = 8'h92; rd_src_data[2] = 8'h93;
    rd_src_resp[0] = 2'd0; rd_src_resp[1] = 2'd0; rd_src_resp[2] = 2'd1;
    run_read(8'h34, 4'd1, 4'd7, 3, 0);
  endtask

  task automatic test_write_toggle();
    wr_src[0] = 8'hC1; wr_src[1] = 8'hC2; wr_src[2] = 8'hC3; wr_src[3] = 8'h00;
    wr_pat[0] = 1'b1; wr_pat[1] = 1'b0; wr_pat[2] = 1'b1; wr_pat[3] = 1'b1;
    wr_npat = 4;
    run_write(8'h50, 4'd2, 4'd9, 2'd0, 1);
  endtask

  task automatic test_back_to_back();
    rd_src_data[0] = 8'hB1; rd_src_resp[0] = 2'd0;
    run_read(8'h60, 4'd0, 4'd1, 1, 0);
    rd_src_data[0] = 8'hB2; rd_src_resp[0] = 2'd3;
    run_read(8'h61, 4'd0, 4'd2, 1, 0);
  endtask

  task automatic test_concurrent();
    rd_src_data[0] = 8'hD1; rd_src_data[1] = 8'hD2;
    rd_src_resp[0] = 2'd1; rd_src_resp[1] = 2'd0;
    wr_src[0] = 8'hE1; wr_src[1] = 8'hE2; wr_src[2] = 8'hE3; wr_src[3] = 8'hE4; wr_src[4] = 8'h00;
    wr_npat = 0;
    fork
      run_read(8'h40, 4'd1, 4'd4, 2, 0);
      run_write(8'h80, 4'd3, 4'd6, 2'd2, 0);
    join
  endtask

  task automatic test_reset_mid();
    rd_req = 1'b1; rd_addr = 8'h20; rd_len = 4'd3; rd_id = 4'd8;
    @(posedge clk); #1;
    rd_req = 1'b0; ARREADY = 1'b1;
    @(posedge clk); #1;
    ARREADY = 1'b0;
    RVALID = 1'b1; RDATA = 8'hA1; RRESP = 2'd2; RLAST = 1'b0;
    @(posedge clk); #1;
    RDATA = 8'hA2;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_async");
    RVALID = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset_mid_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_src_data[0] = 8'hF1; rd_src_data[1] = 8'hF2;
    rd_src_resp[0] = 2'd0; rd_src_resp[1] = 2'd0;
    run_read(8'h28, 4'd1, 4'd8, 2, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    rd_req = 1'b0; rd_addr = '0; rd_len = '0; rd_id = '0;
    wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_id = '0; wr_data = '0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0; RLAST = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;
    wr_npat = 0;
    test_reset();
    test_read_basic();
    test_read_resp_accum();
    test_read_short();
    test_read_long();
    test_write_toggle();
    test_back_to_back();
    test_concurrent();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
